rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order WB stage and an out-of-order long-latency unit (multi-cycle mul/div or late load return). WB traffic has fixed priority because the pipeline cannot hold. Long-unit results are buffered in a small FIFO and drained into idle WB slots. The block keeps a per-register busy scoreboard for the hazard unit. It raises a stall request when the long-unit result is starved or its buffer is full.

---
 rtl/rv32_pkg.sv | 13 +
 rtl/rf_wr_fifo.sv | 50 +++++
 rtl/rf_write_arbiter.sv | 109 ++++++++++
 tb/tb_rf_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the register-file write request record used by
// the write-port arbiter and its result buffer.
package rv32_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } rf_wr_req_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// In-order synchronous FIFO for buffered register-file writes; depth must be
// a power of two so the pointers wrap naturally.
module rf_wr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = rv32_pkg::rf_wr_req_t
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (fixed priority) and a
// buffered long-latency unit; tracks pending destinations and starvation.
module rf_write_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        wb_we,
    input  logic [4:0]                  wb_waddr,
    input  logic [DATA_W-1:0]           wb_wdata,
    input  logic                        lu_valid,
    output logic                        lu_ready,
    input  logic [4:0]                  lu_waddr,
    input  logic [DATA_W-1:0]           lu_wdata,
    input  logic                        issue_valid,
    input  logic [4:0]                  issue_rd,
    output logic                        rf_we,
    output logic [4:0]                  rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [NUM_REGS-1:0]         rd_busy,
    output logic                        stall_req,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

    rf_wr_req_t         lu_entry;
    rf_wr_req_t         head;
    rf_wr_req_t         out_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               wb_req;
    logic               lu_push;
    logic               pop;
    logic [WW-1:0]      wait_cnt;
    logic [WW-1:0]      wait_next;
    logic [CW-1:0]      count_next;
    logic [NUM_REGS-1:0] busy_next;

    // Writes to x0 are no-ops: WB yields its slot, long-unit results are dropped.
    assign wb_req   = wb_we && (wb_waddr != REG_X0);
    assign lu_ready = !fifo_full;
    assign lu_push  = lu_valid && lu_ready && (lu_waddr != REG_X0);
    assign pop      = !wb_req && !fifo_empty;
    assign lu_entry = '{waddr: lu_waddr, wdata: lu_wdata};

    assign rf_waddr = out_q.waddr;
    assign rf_wdata = out_q.wdata;

    rf_wr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (rf_wr_req_t)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (lu_push),
        .wdata (lu_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        count_next = fifo_count;
        if (lu_push && !pop)      count_next = fifo_count + 1'b1;
        else if (pop && !lu_push) count_next = fifo_count - 1'b1;

        wait_next = wait_cnt;
        if (fifo_empty || pop)          wait_next = '0;
        else if (wait_cnt != MAX_WAIT_C) wait_next = wait_cnt + 1'b1;

        // Clear before set so a same-edge issue to the committing rd keeps it busy.
        busy_next = rd_busy;
        if (pop) busy_next[head.waddr] = 1'b0;
        if (issue_valid && issue_rd != REG_X0) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            rf_we     <= 1'b0;
            out_q     <= '0;
            rd_busy   <= '0;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            if (wb_req) begin
                rf_we <= 1'b1;
                out_q <= '{waddr: wb_waddr, wdata: wb_wdata};
            end else if (pop) begin
                rf_we <= 1'b1;
                out_q <= head;
            end else begin
                rf_we <= 1'b0;
            end
            rd_busy   <= busy_next;
            wait_cnt  <= wait_next;
            stall_req <= (wait_next == MAX_WAIT_C) || (count_next == DEPTH_C);
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_rf_write_arbiter;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXW  = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_;
    logic          wb_we;
    logic [4:0]    wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_waddr;
    logic [DW-1:0] lu_wdata;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   rd_busy;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW),
        .DATA_W     (DW)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_waddr    (lu_waddr),
        .lu_wdata    (lu_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rd_busy     (rd_busy),
        .stall_req   (stall_req),
        .fifo_count  (fifo_count)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    int          m_wait;
    logic        m_stall;

    // Reference: the pending long-unit results are a queue; WB to a nonzero
    // register always wins the port, otherwise the oldest queued result goes.
    task automatic model_edge();
        bit   wb_req;
        bit   pop;
        bit   ready;
        int   occ;
        ent_t h;
        if (rst_) begin
            mq.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_wait = 0; m_stall = 0;
            return;
        end
        occ    = mq.size();
        ready  = occ < DEPTH;
        wb_req = wb_we && (wb_waddr != 0);
        pop    = !wb_req && occ > 0;
        if (wb_req) begin
            m_we = 1; m_addr = wb_waddr; m_data = wb_wdata;
        end else if (pop) begin
            h = mq.pop_front();
            m_we = 1; m_addr = h.a; m_data = h.d;
            m_busy[h.a] = 1'b0;
        end else begin
            m_we = 0;
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (occ > 0 && !pop) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
        else                 m_wait = 0;
        if (lu_valid && ready && lu_waddr != 0) mq.push_back('{a: lu_waddr, d: lu_wdata});
        m_stall = (m_wait == MAXW) || (mq.size() == DEPTH);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic test_reset();
        rst_ = 1;
        for (int i = 0; i < 2; i++) begin
            wb_we = 1'($urandom); wb_waddr = 5'($urandom); wb_wdata = $urandom;
            lu_valid = 1'($urandom); lu_waddr = 5'($urandom); lu_wdata = $urandom;
            issue_valid = 1'($urandom); issue_rd = 5'($urandom);
            step();
        end
        checks++; if (rf_we !== 1'b0)      begin errors++; $display("FAIL reset_rf_we: got %0h want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0)   begin errors++; $display("FAIL reset_rf_waddr: got %0h want 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0)  begin errors++; $display("FAIL reset_rf_wdata: got %0h want 0", rf_wdata); end
        checks++; if (rd_busy !== 32'd0)   begin errors++; $display("FAIL reset_rd_busy: got %0h want 0", rd_busy); end
        checks++; if (stall_req !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %0h want 0", stall_req); end
        checks++; if (fifo_count !== '0)   begin errors++; $display("FAIL reset_count: got %0h want 0", fifo_count); end
        rst_ = 0;
        idle();
        #1;
        checks++; if (lu_ready !== 1'b1)   begin errors++; $display("FAIL reset_lu_ready: got %0h want 1", lu_ready); end
    endtask

    task automatic test_wb_only();
        idle();
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
        step();
        idle();
        checks++; if (rf_we !== 1'b1)          begin errors++; $display("FAIL wb_rf_we: got %0h want 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5)       begin errors++; $display("FAIL wb_rf_waddr: got %0h want 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_rf_wdata: got %0h want deadbeef", rf_wdata); end
        step();
        checks++; if (rf_we !== 1'b0)          begin errors++; $display("FAIL wb_rf_we_after: got %0h want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd5)       begin errors++; $display("FAIL wb_hold_waddr: got %0h want 5", rf_waddr); end
    endtask

    task automatic test_conflict();
        idle();
        wb_we = 1; wb_waddr = 3; wb_wdata = 32'h11;
        lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h22;
        step();
        idle();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11)
            begin errors++; $display("FAIL conflict_wb_first: got we=%0h a=%0h d=%0h want 1/3/11", rf_we, rf_waddr, rf_wdata); end
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL conflict_count: got %0h want 1", fifo_count); end
        step();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22)
            begin errors++; $display("FAIL conflict_lu_second: got we=%0h a=%0h d=%0h want 1/7/22", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_starvation();
        idle();
        issue_valid = 1; issue_rd = 9;
        step();
        idle();
        wb_we = 1; wb_waddr = 1; wb_wdata = 32'hAAAA;
        lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h9999;
        step();
        lu_valid = 0;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_stall_0: got %0h want 0", stall_req); end
        for (int k = 1; k <= int'(MAXW); k++) begin
            wb_wdata = $urandom;
            step();
            checks++; if (stall_req !== (k == int'(MAXW)))
                begin errors++; $display("FAIL starve_stall_%0d: got %0h want %0h", k, stall_req, (k == int'(MAXW))); end
        end
        checks++; if (rd_busy[9] !== 1'b1) begin errors++; $display("FAIL starve_busy9_set: got %0h want 1", rd_busy[9]); end
        wb_we = 0;
        step();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999)
            begin errors++; $display("FAIL starve_commit: got we=%0h a=%0h d=%0h want 1/9/9999", rf_we, rf_waddr, rf_wdata); end
        checks++; if (rd_busy[9] !== 1'b0) begin errors++; $display("FAIL starve_busy9_clr: got %0h want 0", rd_busy[9]); end
        checks++; if (stall_req !== 1'b0)  begin errors++; $display("FAIL starve_stall_clr: got %0h want 0", stall_req); end
    endtask

    task automatic test_fifo_full();
        logic [4:0]  got_a[$];
        logic [31:0] got_d[$];
        bit          hs;
        idle();
        wb_we = 1; wb_waddr = 1; wb_wdata = 32'h0101;
        lu_valid = 1; lu_waddr = 20; lu_wdata = 32'hA20;
        step();
        lu_waddr = 21; lu_wdata = 32'hA21;
        step();
        lu_waddr = 22; lu_wdata = 32'hA22;
        checks++; if (lu_ready !== 1'b0)      begin errors++; $display("FAIL full_lu_ready: got %0h want 0", lu_ready); end
        checks++; if (fifo_count !== CW'(2))  begin errors++; $display("FAIL full_count: got %0h want 2", fifo_count); end
        checks++; if (stall_req !== 1'b1)     begin errors++; $display("FAIL full_stall: got %0h want 1", stall_req); end
        wb_we = 0;
        for (int c = 0; c < 12 && got_a.size() < 3; c++) begin
            hs = lu_valid && lu_ready;
            step();
            if (hs) lu_valid = 0;
            if (rf_we && rf_waddr >= 5'd20) begin
                got_a.push_back(rf_waddr);
                got_d.push_back(rf_wdata);
            end
        end
        idle();
        checks++; if (got_a.size() != 3) begin errors++; $display("FAIL full_drain_count: got %0d want 3", got_a.size()); end
        for (int i = 0; i < 3 && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== 5'(20 + i) || got_d[i] !== 32'hA20 + 32'(i))
                begin errors++; $display("FAIL full_order_%0d: got %0h/%0h want %0h/%0h", i, got_a[i], got_d[i], 20 + i, 32'hA20 + 32'(i)); end
        end
    endtask

    task automatic test_scoreboard_x0();
        idle();
        issue_valid = 1; issue_rd = 12;
        step();
        checks++; if (rd_busy[12] !== 1'b1) begin errors++; $display("FAIL sb_set12: got %0h want 1", rd_busy[12]); end
        issue_rd = 0;
        step();
        issue_valid = 0;
        checks++; if (rd_busy !== 32'h0000_1000) begin errors++; $display("FAIL sb_x0_issue: got %0h want 1000", rd_busy); end
        wb_we = 1; wb_waddr = 1; wb_wdata = 32'h5;
        lu_valid = 1; lu_waddr = 12; lu_wdata = 32'h1212;
        step();
        lu_valid = 0;
        wb_waddr = 0; wb_wdata = 32'hFFFF;
        issue_valid = 1; issue_rd = 12;
        step();
        idle();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h1212)
            begin errors++; $display("FAIL sb_x0_slot_pop: got we=%0h a=%0h d=%0h want 1/c/1212", rf_we, rf_waddr, rf_wdata); end
        checks++; if (rd_busy[12] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %0h want 1", rd_busy[12]); end
        lu_valid = 1; lu_waddr = 0; lu_wdata = 32'h7777;
        step();
        idle();
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL sb_lu_x0_drop: got %0h want 0", fifo_count); end
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'h3333;
        step();
        idle();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd12)
            begin errors++; $display("FAIL sb_wb_x0: got we=%0h a=%0h want 0/c", rf_we, rf_waddr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_        = ($urandom_range(0, 63) == 0);
            wb_we       = ($urandom_range(0, 9) < 6);
            wb_waddr    = 5'($urandom_range(0, 7));
            wb_wdata    = $urandom;
            lu_valid    = ($urandom_range(0, 9) < 4);
            lu_waddr    = 5'($urandom_range(0, 15));
            lu_wdata    = $urandom;
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_rd    = 5'($urandom_range(0, 15));
            step();
            rst_ = 0;
            checks++; if (rf_we !== m_we)       begin errors++; $display("FAIL rnd_rf_we@%0d: got %0h want %0h", n, rf_we, m_we); end
            checks++; if (rf_waddr !== m_addr)  begin errors++; $display("FAIL rnd_rf_waddr@%0d: got %0h want %0h", n, rf_waddr, m_addr); end
            checks++; if (rf_wdata !== m_data)  begin errors++; $display("FAIL rnd_rf_wdata@%0d: got %0h want %0h", n, rf_wdata, m_data); end
            checks++; if (rd_busy !== m_busy)   begin errors++; $display("FAIL rnd_rd_busy@%0d: got %0h want %0h", n, rd_busy, m_busy); end
            checks++; if (stall_req !== m_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %0h want %0h", n, stall_req, m_stall); end
            checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0h want %0h", n, fifo_count, mq.size()); end
            checks++; if (lu_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_lu_ready@%0d: got %0h want %0h", n, lu_ready, (mq.size() < DEPTH)); end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_ = 1;
        test_reset();
        test_wb_only();
        test_conflict();
        test_starvation();
        test_fifo_full();
        test_scoreboard_x0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
